// File: rtl/deque_pkg.sv
// deque_pkg: opcode constants and FSM state encoding shared by the deque command sequencer
package deque_pkg;
   localparam logic [1:0] OP_PUSH = 2'b00;
   localparam logic [1:0] OP_POP  = 2'b01;
   localparam logic [1:0] OP_PEEK = 2'b10;
   localparam logic [1:0] OP_MOVE = 2'b11;
   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_DATA,
      S_EXEC,
      S_MOVE_PUSH,
      S_RESP
   } state_t;
endpackage

// File: rtl/deque_ctrl.sv
// deque_ctrl: byte-serial command sequencer driving the two stacks of the dual deque
//   in_valid/in_ready/in_data      command and PUSH data bytes from the host
//   out_valid/out_ready/out_data/out_err   one response per command
//   empty0/1, full0/1, stk_rdata   stack status and top-of-stack (ORed) data
//   stack_select, push, pop, data_in      stack control strobes
module deque_ctrl
   import deque_pkg::*;
#(
   parameter int SEL_BIT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_err,
   input  logic       empty0,
   input  logic       empty1,
   input  logic       full0,
   input  logic       full1,
   input  logic [7:0] stk_rdata,
   output logic       stack_select,
   output logic       push,
   output logic       pop,
   output logic [7:0] data_in
);
   state_t     state_q;
   logic [1:0] op_q;
   logic       sel_q;
   logic [7:0] data_q;
   logic [7:0] out_data_q;
   logic       out_err_q;
   logic       exec, mpush, src_empty, src_full, dst_full, ok;
   assign exec      = state_q == S_EXEC;
   assign mpush     = state_q == S_MOVE_PUSH;
   assign src_empty = sel_q ? empty1 : empty0;
   assign src_full  = sel_q ? full1 : full0;
   assign dst_full  = sel_q ? full0 : full1;
   // Whether the command in EXEC can run; flags are only meaningful in EXEC
   assign ok = (op_q == OP_PUSH) ? !src_full :
               (op_q == OP_MOVE) ? (!src_empty && !dst_full) : !src_empty;
   // Strobes decode from registered state and stack flags only
   assign push         = (exec && op_q == OP_PUSH && ok) || mpush;
   assign pop          = exec && ok && (op_q == OP_POP || op_q == OP_MOVE);
   assign stack_select = exec ? sel_q : mpush ? ~sel_q : 1'b0;
   assign data_in      = push ? data_q : 8'h00;
   // Gated by rst so the host sees no ready while reset is held
   assign in_ready  = !rst && (state_q == S_IDLE || state_q == S_WAIT_DATA);
   assign out_valid = state_q == S_RESP;
   assign out_data  = out_data_q;
   assign out_err   = out_err_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         op_q       <= OP_PUSH;
         sel_q      <= 1'b0;
         data_q     <= 8'h00;
         out_data_q <= 8'h00;
         out_err_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: if (in_valid) begin
               op_q    <= in_data[7:6];
               sel_q   <= in_data[SEL_BIT];
               state_q <= (in_data[7:6] == OP_PUSH) ? S_WAIT_DATA : S_EXEC;
            end
            S_WAIT_DATA: if (in_valid) begin
               data_q  <= in_data;
               state_q <= S_EXEC;
            end
            S_EXEC: begin
               out_data_q <= (op_q != OP_PUSH && ok) ? stk_rdata : 8'h00;
               out_err_q  <= !ok;
               // MOVE keeps the popped byte to push into the other stack next cycle
               if (op_q == OP_MOVE) data_q <= stk_rdata;
               state_q    <= (op_q == OP_MOVE && ok) ? S_MOVE_PUSH : S_RESP;
            end
            S_MOVE_PUSH: state_q <= S_RESP;
            S_RESP: if (out_ready) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_deque_ctrl.sv
// tb_deque_ctrl: self-checking bench for deque_ctrl with emulated stacks and a queue-based reference
module tb_deque_ctrl;
   localparam int SEL   = 0;
   localparam int DEPTH = 16;
   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, out_valid, out_ready, out_err;
   logic [7:0] in_data, out_data, stk_rdata, data_in;
   logic       empty0, empty1, full0, full1, stack_select, push, pop;
   int checks = 0;
   int errors = 0;
   logic [7:0] mem0 [DEPTH];
   logic [7:0] mem1 [DEPTH];
   logic [4:0] cnt0 = 5'd0;
   logic [4:0] cnt1 = 5'd0;
   int cyc = 0, push_cnt = 0, pop_cnt = 0;
   int last_pop_cyc = 0, last_push_cyc = 0;
   logic last_pop_sel = 1'b0, last_push_sel = 1'b0, both_seen = 1'b0;
   logic [7:0] last_push_data = 8'h00;
   logic [7:0] rq0[$], rq1[$];
   always #5 clk = ~clk;
   deque_ctrl #(.SEL_BIT(SEL)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
      .empty0(empty0), .empty1(empty1), .full0(full0), .full1(full1), .stk_rdata(stk_rdata),
      .stack_select(stack_select), .push(push), .pop(pop), .data_in(data_in)
   );
   assign empty0 = cnt0 == 5'd0;
   assign empty1 = cnt1 == 5'd0;
   assign full0  = cnt0 == 5'(DEPTH);
   assign full1  = cnt1 == 5'(DEPTH);
   assign stk_rdata = stack_select ? (empty1 ? 8'h00 : mem1[4'(cnt1 - 5'd1)])
                                   : (empty0 ? 8'h00 : mem0[4'(cnt0 - 5'd1)]);
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (push && pop) both_seen <= 1'b1;
      if (push) begin
         push_cnt       <= push_cnt + 1;
         last_push_sel  <= stack_select;
         last_push_data <= data_in;
         last_push_cyc  <= cyc;
         if (stack_select && cnt1 < 5'(DEPTH)) begin
            mem1[cnt1[3:0]] <= data_in;
            cnt1 <= cnt1 + 5'd1;
         end else if (!stack_select && cnt0 < 5'(DEPTH)) begin
            mem0[cnt0[3:0]] <= data_in;
            cnt0 <= cnt0 + 5'd1;
         end
      end
      if (pop) begin
         pop_cnt      <= pop_cnt + 1;
         last_pop_sel <= stack_select;
         last_pop_cyc <= cyc;
         if (stack_select && cnt1 != 5'd0) cnt1 <= cnt1 - 5'd1;
         else if (!stack_select && cnt0 != 5'd0) cnt0 <= cnt0 - 5'd1;
      end
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // Reference: command-level semantics on two queues
   task automatic model(input logic [7:0] cmd, input logic [7:0] dat, output logic [7:0] d,
                        output logic e, output int np, output int nq, output bit mv);
      logic s;
      int   sz_s, sz_d;
      s    = cmd[SEL];
      sz_s = s ? rq1.size() : rq0.size();
      sz_d = s ? rq0.size() : rq1.size();
      d = 8'h00; e = 1'b0; np = 0; nq = 0; mv = 1'b0;
      case (cmd[7:6])
         2'b00: if (sz_s == DEPTH) e = 1'b1;
                else begin
                   np = 1;
                   if (s) rq1.push_back(dat); else rq0.push_back(dat);
                end
         2'b01, 2'b10: if (sz_s == 0) e = 1'b1;
                else begin
                   d = s ? rq1[$] : rq0[$];
                   if (cmd[7:6] == 2'b01) begin
                      nq = 1;
                      if (s) void'(rq1.pop_back()); else void'(rq0.pop_back());
                   end
                end
         default: if (sz_s == 0 || sz_d == DEPTH) e = 1'b1;
                else begin
                   np = 1; nq = 1; mv = 1'b1;
                   if (s) begin d = rq1.pop_back(); rq0.push_back(d); end
                   else begin d = rq0.pop_back(); rq1.push_back(d); end
                end
      endcase
   endtask
   task automatic send(input logic [7:0] b);
      int t;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      t = 0;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("in_ready_wait", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask
   task automatic do_cmd(input logic [7:0] cmd, input logic [7:0] dat, input int hold);
      logic [7:0] ed, hd;
      logic       ee, he;
      int         np, nq, pc0, qc0, lat;
      bit         mv;
      model(cmd, dat, ed, ee, np, nq, mv);
      pc0 = push_cnt;
      qc0 = pop_cnt;
      send(cmd);
      if (cmd[7:6] == 2'b00) send(dat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 20);
      chk("latency", lat, mv ? 3 : 2);
      hd = out_data;
      he = out_err;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", out_valid, 1);
         chk("hold_data", {out_err, out_data}, {he, hd});
         chk("hold_in_ready", in_ready, 0);
      end
      chk("resp_data", out_data, ed);
      chk("resp_err", out_err, ee);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("idle_in_ready", in_ready, 1);
      chk("idle_out_valid", out_valid, 0);
      chk("push_strobes", push_cnt - pc0, np);
      chk("pop_strobes", pop_cnt - qc0, nq);
      if (mv) begin
         chk("move_pop_sel", last_pop_sel, cmd[SEL]);
         chk("move_push_sel", last_push_sel, !cmd[SEL]);
         chk("move_push_data", last_push_data, ed);
         chk("move_order", last_push_cyc, last_pop_cyc + 1);
      end
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      int pc0;
      logic [7:0] cmd;
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out", {out_err, out_data}, 9'h000);
      chk("rst_strobes", {push, pop, stack_select, data_in}, 11'h000);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      do_cmd(8'h00, 8'hA5, 0);
      do_cmd(8'h40, 8'h00, 0);
      chk("s0_empty", cnt0, 0);
      do_cmd(8'h41, 8'h00, 0);
      do_cmd(8'h00, 8'h11, 0);
      do_cmd(8'h00, 8'h22, 0);
      do_cmd(8'h80, 8'h00, 1);
      do_cmd(8'h80, 8'h00, 0);
      do_cmd(8'h40, 8'h00, 0);
      do_cmd(8'h40, 8'h00, 0);
      do_cmd(8'h00, 8'h3C, 0);
      do_cmd(8'hC0, 8'h00, 0);
      do_cmd(8'h41, 8'h00, 0);
      for (int i = 0; i < DEPTH; i++) do_cmd(8'h01, 8'(i * 7 + 3), 0);
      chk("s1_full", full1, 1);
      do_cmd(8'h01, 8'hFF, 0);
      do_cmd(8'h00, 8'h5A, 0);
      do_cmd(8'hC0, 8'h00, 0);
      do_cmd(8'h40, 8'h00, 5);
      // Reset while waiting for a PUSH data byte
      pc0 = push_cnt;
      send(8'h00);
      @(negedge clk);
      chk("wait_in_ready", in_ready, 1);
      rst = 1'b1;
      #1;
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_push", push, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("after_rst_in_ready", in_ready, 1);
      chk("after_rst_valid", out_valid, 0);
      chk("after_rst_pushes", push_cnt - pc0, 0);
      do_cmd(8'h41, 8'h00, 0);
      for (int i = 0; i < 200; i++) begin
         int r;
         r = $urandom_range(0, 9);
         cmd = {(r < 4) ? 2'b00 : (r < 6) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11, 6'($urandom)};
         do_cmd(cmd, 8'($urandom), $urandom_range(0, 3));
      end
      chk("final_cnt0", cnt0, rq0.size());
      chk("final_cnt1", cnt1, rq1.size());
      for (int i = 0; i < rq0.size() && i < DEPTH; i++) chk("final_s0", mem0[i], rq0[i]);
      for (int i = 0; i < rq1.size() && i < DEPTH; i++) chk("final_s1", mem1[i], rq1[i]);
      chk("push_pop_exclusive", both_seen, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
